way_write_demux: RTL and testbench

- Parametrised, registered 1-to-NUM_WAYS write demultiplexer for the set-associative write-back cache datapath.
- Routes one write beat (data plus way select) from the cache controller to one way, or to all ways (broadcast, e.g. invalidate/fill).
- Uses valid/ready handshakes on both sides and accepts independent per-way back-pressure.
- Output stage is a single-entry buffer with a pending-way mask, so a broadcast completes only after every way has accepted.

---
 rtl/way_write_demux.sv | 65 ++++++
 tb/tb_way_write_demux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/way_write_demux.sv
// way_write_demux: registered 1-to-NUM_WAYS write demultiplexer for the cache
// write datapath. A single-entry buffer holds one beat together with a mask of
// the ways that still have to take it, so unicast and broadcast beats share
// one mechanism: a beat retires once its pending mask has drained to zero.
module way_write_demux #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    input  logic                  in_bcast,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_WAYS-1:0]   out_valid,
    input  logic [NUM_WAYS-1:0]   out_ready,
    output logic                  busy
);

    // Way select must cover the ways exactly, so every select value is legal.
    if (NUM_WAYS < 2 || SEL_WIDTH != $clog2(NUM_WAYS) || (1 << SEL_WIDTH) != NUM_WAYS) begin : g_param_check
        $error("way_write_demux: NUM_WAYS must be a power of 2 (>=2) and SEL_WIDTH = log2(NUM_WAYS)");
    end

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [NUM_WAYS-1:0]   pend_q;
    logic [NUM_WAYS-1:0]   pend_d;
    logic [NUM_WAYS-1:0]   rem;
    logic [NUM_WAYS-1:0]   sel_mask;
    logic                  load;

    // Drain/accept decision and next-state for the held beat and pending mask.
    always_comb begin
        rem      = pend_q & ~out_ready;
        in_ready = (rem == '0);
        load     = in_valid & in_ready;
        sel_mask = NUM_WAYS'(1) << in_sel;
        data_d   = data_q;
        pend_d   = rem;
        if (load) begin
            data_d = in_data;
            pend_d = in_bcast ? '1 : sel_mask;
        end
    end

    // Buffer registers; reset discards any held beat and drops a same-cycle offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= '0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign busy      = |pend_q;

endmodule

// File: tb/tb_way_write_demux.sv
// Bench for way_write_demux: directed cycle table for the corner cases, a
// randomized phase checked by a per-way transaction scoreboard, and a short
// directed sequence on an 8-way / 32-bit instance.
module tb_way_write_demux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 4-way, 16-bit instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    way_write_demux #(.DATA_WIDTH(16), .NUM_WAYS(4), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    // 8-way, 32-bit instance
    logic        rst8;
    logic        iv8;
    logic        ird8;
    logic [31:0] d8;
    logic [2:0]  sel8;
    logic        bc8;
    logic [31:0] od8;
    logic [7:0]  ov8;
    logic [7:0]  ordy8;
    logic        busy8;

    way_write_demux #(.DATA_WIDTH(32), .NUM_WAYS(8), .SEL_WIDTH(3)) dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(iv8), .in_ready(ird8), .in_data(d8),
        .in_sel(sel8), .in_bcast(bc8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8),
        .busy(busy8)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus and the expected response.
    // eird: in_ready during the cycle; eov/eod/ebusy: outputs after the edge.
    typedef struct {
        logic        rst;
        logic        iv;
        logic [1:0]  sel;
        logic        bc;
        logic [15:0] d;
        logic [3:0]  ordy;
        logic        cird;
        logic        eird;
        logic [3:0]  eov;
        logic [15:0] eod;
        logic        ebusy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] sel,
                                input logic bc, input logic [15:0] d, input logic [3:0] ordy,
                                input logic cird, input logic eird, input logic [3:0] eov,
                                input logic [15:0] eod, input logic ebusy);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = sel; v.bc = bc; v.d = d; v.ordy = ordy;
        v.cird = cird; v.eird = eird; v.eov = eov; v.eod = eod; v.ebusy = ebusy;
        return v;
    endfunction

    localparam int NV = 28;
    vec_t vecs [NV];
    vec_t expq [$];
    logic [15:0] wq [4][$];

    // Randomized cycle: scoreboard of beats owed to each way.
    task automatic rstep(input logic iv, input logic [1:0] sel, input logic bc,
                         input logic [15:0] d, input logic [3:0] ordy, input int cyc);
        logic exp_ird;
        logic any;
        logic [15:0] want;
        in_valid = iv; in_sel = sel; in_bcast = bc; in_data = d; out_ready = ordy; rst = 1'b0;
        @(negedge clk);
        exp_ird = 1'b1;
        any     = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (wq[w].size() != 0) begin
                any = 1'b1;
                if (!ordy[w]) exp_ird = 1'b0;
            end
            chk($sformatf("rnd%0d out_valid[%0d]", cyc, w), 64'(out_valid[w]), 64'(wq[w].size() != 0));
        end
        chk($sformatf("rnd%0d in_ready", cyc), 64'(in_ready), 64'(exp_ird));
        chk($sformatf("rnd%0d busy", cyc), 64'(busy), 64'(any));
        for (int w = 0; w < 4; w++) begin
            if (wq[w].size() != 0 && ordy[w]) begin
                want = wq[w].pop_front();
                chk($sformatf("rnd%0d data way%0d", cyc, w), 64'(out_data), 64'(want));
            end
        end
        if (iv && exp_ird) begin
            for (int w = 0; w < 4; w++)
                if (bc || sel == 2'(w)) wq[w].push_back(d);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t e;
        logic [15:0] sh;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
        rst8 = 1'b1; iv8 = 1'b0; d8 = '0; sel8 = '0; bc8 = 1'b0; ordy8 = '0;

        //               rst iv sel bc  data      ordy    cird eird ov       od        busy
        // reset with a beat offered: beat dropped
        vecs[0]  = mk(1, 1, 2'd0, 0, 16'hFFFF, 4'b0000, 0, 0, 4'b0000, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 0);
        // single write, one-cycle latency
        vecs[2]  = mk(0, 1, 2'd1, 0, 16'hA5A5, 4'b1111, 1, 1, 4'b0010, 16'hA5A5, 1);
        vecs[3]  = mk(0, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 1, 4'b0000, 16'hA5A5, 0);
        // back-to-back at full throughput
        vecs[4]  = mk(0, 1, 2'd0, 0, 16'h0001, 4'b1111, 1, 1, 4'b0001, 16'h0001, 1);
        vecs[5]  = mk(0, 1, 2'd1, 0, 16'h0002, 4'b1111, 1, 1, 4'b0010, 16'h0002, 1);
        vecs[6]  = mk(0, 1, 2'd2, 0, 16'h0003, 4'b1111, 1, 1, 4'b0100, 16'h0003, 1);
        vecs[7]  = mk(0, 1, 2'd3, 0, 16'h0004, 4'b1111, 1, 1, 4'b1000, 16'h0004, 1);
        vecs[8]  = mk(0, 0, 2'd0, 0, 16'h0000, 4'b1111, 1, 1, 4'b0000, 16'h0004, 0);
        // staggered broadcast
        vecs[9]  = mk(0, 1, 2'd0, 1, 16'hBEEF, 4'b0000, 1, 1, 4'b1111, 16'hBEEF, 1);
        vecs[10] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0001, 1, 0, 4'b1110, 16'hBEEF, 1);
        vecs[11] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0100, 1, 0, 4'b1010, 16'hBEEF, 1);
        vecs[12] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b1000, 1, 0, 4'b0010, 16'hBEEF, 1);
        vecs[13] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0010, 1, 1, 4'b0000, 16'hBEEF, 0);
        // back-pressure stall on way 3 with a second beat waiting
        vecs[14] = mk(0, 1, 2'd3, 0, 16'h1234, 4'b0000, 1, 1, 4'b1000, 16'h1234, 1);
        for (int k = 15; k < 20; k++)
            vecs[k] = mk(0, 1, 2'd0, 0, 16'h5678, 4'b0111, 1, 0, 4'b1000, 16'h1234, 1);
        vecs[20] = mk(0, 1, 2'd0, 0, 16'h5678, 4'b1000, 1, 1, 4'b0001, 16'h5678, 1);
        vecs[21] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0001, 1, 1, 4'b0000, 16'h5678, 0);
        // reset during HOLD
        vecs[22] = mk(0, 1, 2'd2, 0, 16'h7777, 4'b0000, 1, 1, 4'b0100, 16'h7777, 1);
        vecs[23] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0000, 1, 0, 4'b0100, 16'h7777, 1);
        vecs[24] = mk(1, 0, 2'd0, 0, 16'h0000, 4'b0000, 1, 0, 4'b0000, 16'h0000, 0);
        vecs[25] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 0);
        // beat offered during reset from EMPTY is dropped
        vecs[26] = mk(1, 1, 2'd1, 0, 16'h4242, 4'b0000, 1, 1, 4'b0000, 16'h0000, 0);
        vecs[27] = mk(0, 0, 2'd0, 0, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 0);

        @(posedge clk); #1;
        rst8 = 1'b0;

        // directed table
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_sel = vecs[i].sel;
            in_bcast = vecs[i].bc; in_data = vecs[i].d; out_ready = vecs[i].ordy;
            expq.push_back(vecs[i]);
            @(negedge clk);
            if (vecs[i].cird) chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].eird));
            @(posedge clk); #1;
            e = expq.pop_front();
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(e.eov));
            chk($sformatf("v%0d out_data", i), 64'(out_data), 64'(e.eod));
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(e.ebusy));
        end

        // randomized traffic with random per-way back-pressure
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r;
            for (int w = 0; w < 4; w++) r[w] = ($urandom_range(0, 3) != 0);
            rstep(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 16'($urandom), r, c);
        end
        for (int c = 0; c < 3; c++) rstep(1'b0, 2'd0, 1'b0, 16'h0, 4'b1111, 400 + c);
        for (int w = 0; w < 4; w++) chk($sformatf("drain way%0d", w), 64'(wq[w].size()), 64'd0);
        chk("drain out_valid", 64'(out_valid), 64'd0);

        // 8-way instance: unicast to way 7
        iv8 = 1'b1; sel8 = 3'd7; bc8 = 1'b0; d8 = 32'hDEADBEEF; ordy8 = 8'h00;
        @(negedge clk);
        chk("w8 in_ready idle", 64'(ird8), 64'd1);
        @(posedge clk); #1;
        chk("w8 out_valid sel7", 64'(ov8), 64'h80);
        chk("w8 out_data sel7", 64'(od8), 64'hDEADBEEF);
        iv8 = 1'b0; ordy8 = 8'h80;
        @(posedge clk); #1;
        chk("w8 out_valid drained", 64'(ov8), 64'h00);
        // 8-way broadcast, ways accept one per cycle
        iv8 = 1'b1; bc8 = 1'b1; d8 = 32'h0BADF00D; ordy8 = 8'h00;
        @(posedge clk); #1;
        chk("w8 bcast out_valid", 64'(ov8), 64'hFF);
        iv8 = 1'b0; bc8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ordy8 = 8'(16'h1 << k);
            @(negedge clk);
            chk($sformatf("w8 bcast in_ready k%0d", k), 64'(ird8), 64'(k == 7));
            @(posedge clk); #1;
            sh = 16'h00FF << (k + 1);
            chk($sformatf("w8 bcast out_valid k%0d", k), 64'(ov8), 64'(sh[7:0]));
            chk($sformatf("w8 bcast out_data k%0d", k), 64'(od8), 64'h0BADF00D);
        end
        chk("w8 busy end", 64'(busy8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
